// File: rtl/eeg_frame_aligner.sv
// eeg_frame_aligner
// Finds the frame boundary in the deserializer's sliding window by matching
// SYNC, captures WORDS data words per frame, packs them (first word in the
// LSBs) and presents the sample on a valid/ready register. Reports lock and a
// one-cycle overflow pulse when a completed sample cannot be stored.
// Optional flywheel: define EEG_ALIGN_FLYWHEEL_EN to ride through up to
// LOCK_MISS-1 consecutive sync misses without dropping lock.
//
// state   | meaning
// S_HUNT  | compare the window with SYNC on every cycle
// S_DATA  | capture one word every WIDTH cycles until WORDS are in
// S_CHECK | expect SYNC at the next word boundary
module eeg_frame_aligner #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] SYNC      = 4'hA,
  parameter int               WORDS     = 3,
  parameter int               LOCK_MISS = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       eegIn,
  output logic [WIDTH*WORDS-1:0] sample,
  output logic                   sample_valid,
  input  logic                   sample_ready,
  output logic                   locked,
  output logic                   overflow
);

  localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int WCW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int SW  = WIDTH * WORDS;
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(WIDTH - 1);
  localparam logic [WCW-1:0] WORD_LAST = WCW'(WORDS - 1);

  typedef enum logic [1:0] {S_HUNT, S_DATA, S_CHECK} state_t;

  state_t         state_q;
  logic [BCW-1:0] bit_cnt_q;
  logic [WCW-1:0] word_cnt_q;
  logic [SW-1:0]  words_q;
  logic [SW-1:0]  words_d;
  logic [SW-1:0]  sample_q;
  logic           valid_q;
  logic           locked_q;
  logic           overflow_q;

  logic           bit_last;
  logic [BCW-1:0] bit_next;
  logic           sync_hit;
  logic           complete;
  logic           handshake;

`ifdef EEG_ALIGN_FLYWHEEL_EN
  localparam int MCW = $clog2(LOCK_MISS + 1);
  localparam logic [MCW-1:0] MISS_LAST = MCW'(LOCK_MISS - 1);
  logic [MCW-1:0] miss_q;
`else
  logic unused_lock_miss;
  assign unused_lock_miss = (LOCK_MISS != 0);
`endif

  // Word-boundary decode and the frame buffer with the current word slotted in.
  always_comb begin
    bit_last  = (bit_cnt_q == BIT_LAST);
    bit_next  = bit_last ? '0 : bit_cnt_q + 1'b1;
    sync_hit  = (eegIn == SYNC);
    words_d   = words_q;
    for (int k = 0; k < WORDS; k++) begin
      if (word_cnt_q == WCW'(k)) words_d[k*WIDTH +: WIDTH] = eegIn;
    end
    complete  = (state_q == S_DATA) && bit_last && (word_cnt_q == WORD_LAST);
    handshake = valid_q && sample_ready;
  end

  // Alignment FSM, frame capture and the registered output stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_HUNT;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      words_q    <= '0;
      sample_q   <= '0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      overflow_q <= 1'b0;
`ifdef EEG_ALIGN_FLYWHEEL_EN
      miss_q     <= '0;
`endif
    end else begin
      overflow_q <= 1'b0;
      // A slot frees up either when empty or when the consumer takes it now.
      if (complete) begin
        if (!valid_q || sample_ready) begin
          sample_q <= words_d;
          valid_q  <= 1'b1;
        end else begin
          overflow_q <= 1'b1;
        end
      end else if (handshake) begin
        valid_q <= 1'b0;
      end

      case (state_q)
        S_HUNT: begin
          bit_cnt_q  <= '0;
          word_cnt_q <= '0;
          if (sync_hit) state_q <= S_DATA;
        end
        S_DATA: begin
          bit_cnt_q <= bit_next;
          if (bit_last) begin
            words_q <= words_d;
            if (word_cnt_q == WORD_LAST) begin
              word_cnt_q <= '0;
              state_q    <= S_CHECK;
            end else begin
              word_cnt_q <= word_cnt_q + 1'b1;
            end
          end
        end
        S_CHECK: begin
          bit_cnt_q <= bit_next;
          if (bit_last) begin
            if (sync_hit) begin
              locked_q <= 1'b1;
              state_q  <= S_DATA;
`ifdef EEG_ALIGN_FLYWHEEL_EN
              miss_q   <= '0;
`endif
            end else begin
`ifdef EEG_ALIGN_FLYWHEEL_EN
              if (miss_q >= MISS_LAST) begin
                miss_q   <= '0;
                locked_q <= 1'b0;
                state_q  <= S_HUNT;
              end else begin
                miss_q  <= miss_q + 1'b1;
                state_q <= S_DATA;
              end
`else
              locked_q <= 1'b0;
              state_q  <= S_HUNT;
`endif
            end
          end
        end
        default: state_q <= S_HUNT;
      endcase
    end
  end

  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign locked       = locked_q;
  assign overflow     = overflow_q;

endmodule
